ws_field_sequencer: RTL and testbench

- Bit-serial word-timing and field-select controller for the ARC arithmetic datapath.
- Runs the 56-bit word cycle: 14 digits × 4 bits, bit times T0..T55.
- Generates the sync window and captures the serial instruction on is during that window.
- Maintains the digit pointer P and drives ws so the arithmetic unit operates only on the selected field in the following word cycle.
- Sits beside QUAD_ROM/CTC. Its ws is ORed into the shared ws line.

---
 rtl/ws_field_sequencer.sv | 113 +++++++++++
 tb/tb_ws_field_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ws_field_sequencer.sv
// Bit-serial word timer for the ARC datapath: counts bit times, captures the
// serial instruction during sync, tracks pointer P and gates the word-select line.
module ws_field_sequencer #(
   parameter int NBITS      = 56,
   parameter int SYNC_FIRST = 45,
   parameter int IBITS      = 10,
   parameter int NDIG       = 14
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             bit_en,
   input  logic             is,
   input  logic             run,
   output logic [5:0]       bit_cnt,
   output logic [3:0]       digit,
   output logic             sync,
   output logic             word_start,
   output logic             ws,
   output logic [3:0]       p_reg,
   output logic [IBITS-1:0] instr
);

   localparam logic [5:0] LAST_BIT   = 6'(NBITS - 1);
   localparam logic [5:0] SYNC_START = 6'(SYNC_FIRST);
   localparam logic [5:0] SYNC_END   = 6'(SYNC_FIRST + IBITS - 1);
   localparam logic [3:0] PMAX       = 4'(NDIG - 1);

   logic [IBITS-1:0] instr_sr;
   logic             field_valid;
   logic [2:0]       field;
   logic             word_end;
   logic [3:0]       p_next;
   logic             valid_next;
   logic [2:0]       field_next;
   logic             in_span;

   assign word_end = bit_en && (bit_cnt == LAST_BIT);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         bit_cnt <= '0;
      end else if (bit_en) begin
         bit_cnt <= (bit_cnt == LAST_BIT) ? 6'd0 : bit_cnt + 6'd1;
      end
   end

   // Slot k of the sync window lands in instr_sr[k], LSB first.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         instr_sr <= '0;
      end else if (bit_en) begin
         for (int k = 0; k < IBITS; k++) begin
            if (bit_cnt == 6'(SYNC_FIRST + k)) instr_sr[k] <= is;
         end
      end
   end

   always_comb begin
      p_next     = p_reg;
      valid_next = 1'b0;
      field_next = field;
      if (run) begin
         if (instr_sr[1:0] == 2'b10) begin
            valid_next = 1'b1;
            field_next = instr_sr[4:2];
         end else if (instr_sr[1:0] == 2'b00) begin
            case (instr_sr[5:2])
               4'b0011: p_next = (instr_sr[9:6] > PMAX) ? PMAX : instr_sr[9:6];
               4'b0111: p_next = (p_reg == 4'd0) ? PMAX : p_reg - 4'd1;
               4'b1111: p_next = (p_reg == PMAX) ? 4'd0 : p_reg + 4'd1;
               default: p_next = p_reg;
            endcase
         end
      end
   end

   // Decode edge: the captured word takes effect for the whole next word.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         instr       <= '0;
         p_reg       <= '0;
         field_valid <= 1'b0;
         field       <= '0;
      end else if (word_end) begin
         instr       <= instr_sr;
         p_reg       <= p_next;
         field_valid <= valid_next;
         field       <= field_next;
      end
   end

   assign digit      = bit_cnt[5:2];
   assign sync       = (bit_cnt >= SYNC_START) && (bit_cnt <= SYNC_END);
   assign word_start = (bit_cnt == 6'd0);

   always_comb begin
      in_span = 1'b0;
      case (field)
         3'd0: in_span = (digit == p_reg);
         3'd1: in_span = (digit <= p_reg);
         3'd2: in_span = (digit == 4'd2);
         3'd3: in_span = (digit <= 4'd2);
         3'd4: in_span = (digit == PMAX);
         3'd5: in_span = (digit >= 4'd3) && (digit <= 4'd12);
         3'd6: in_span = (digit <= PMAX);
         3'd7: in_span = (digit >= 4'd3) && (digit <= PMAX);
         default: in_span = 1'b0;
      endcase
   end

   assign ws = field_valid && in_span;

endmodule

// File: tb/tb_ws_field_sequencer.sv
// Directed bench for ws_field_sequencer: word-by-word stimulus with
// hand-computed ws spans, pointer values and captured instructions.
module tb_ws_field_sequencer;

   logic       clk = 1'b0;
   logic       rstb;
   logic       bit_en;
   logic       is;
   logic       run;
   logic [5:0] bit_cnt;
   logic [3:0] digit;
   logic       sync;
   logic       word_start;
   logic       ws;
   logic [3:0] p_reg;
   logic [9:0] instr;

   int n_tests = 0;
   int n_fail  = 0;

   ws_field_sequencer dut (
      .clk        (clk),
      .rstb       (rstb),
      .bit_en     (bit_en),
      .is         (is),
      .run        (run),
      .bit_cnt    (bit_cnt),
      .digit      (digit),
      .sync       (sync),
      .word_start (word_start),
      .ws         (ws),
      .p_reg      (p_reg),
      .instr      (instr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int b, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (bit %0d): observed %0h expected %0h", tag, b, obs, exp);
      end
   endtask

   // One word of strobes; ws expected for bit_cnt in [ws_lo, ws_hi], none if lo > hi.
   task automatic word(input string tag, input logic [9:0] ins, input logic run_v,
                       input int ws_lo, input int ws_hi, input int p_exp,
                       input logic [9:0] instr_exp, input int nbits);
      for (int b = 0; b < nbits; b++) begin
         check({tag, ".bit_cnt"}, b, 16'(bit_cnt), 16'(b));
         check({tag, ".sync"}, b, 16'(sync), 16'(b >= 45 && b <= 54));
         check({tag, ".word_start"}, b, 16'(word_start), 16'(b == 0));
         check({tag, ".digit"}, b, 16'(digit), 16'(b / 4));
         check({tag, ".ws"}, b, 16'(ws), 16'(b >= ws_lo && b <= ws_hi));
         if (b == 0) begin
            check({tag, ".p_reg"}, b, 16'(p_reg), 16'(p_exp));
            check({tag, ".instr"}, b, 16'(instr), 16'(instr_exp));
         end
         is     = (b >= 45 && b <= 54) ? ins[b - 45] : 1'b0;
         run    = run_v;
         bit_en = 1'b1;
         @(posedge clk);
         #1 bit_en = 1'b0;
         is = 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (b == 10) check({tag, ".hold"}, b, 16'(bit_cnt), 16'(b + 1));
      end
   endtask

   initial begin
      rstb   = 1'b0;
      bit_en = 1'b0;
      is     = 1'b0;
      run    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.bit_cnt", 0, 16'(bit_cnt), 16'd0);
      check("reset.p_reg", 0, 16'(p_reg), 16'd0);
      check("reset.instr", 0, 16'(instr), 16'd0);
      check("reset.ws", 0, 16'(ws), 16'd0);
      check("reset.sync", 0, 16'(sync), 16'd0);
      check("reset.word_start", 0, 16'(word_start), 16'd1);
      rstb = 1'b1;
      repeat (3) @(negedge clk);
      check("idle.bit_cnt", 0, 16'(bit_cnt), 16'd0);

      word("w1_idle",    10'h000, 1'b1, 1, 0, 0,  10'h000, 56);
      word("w2_capW",    10'h01A, 1'b1, 1, 0, 0,  10'h000, 56);
      word("w3_fieldW",  10'h000, 1'b1, 0, 55, 0, 10'h01A, 56);
      word("w4_setP5",   10'h14C, 1'b1, 1, 0, 0,  10'h000, 56);
      word("w5_capWP",   10'h006, 1'b1, 1, 0, 5,  10'h14C, 56);
      word("w6_fieldWP", 10'h002, 1'b1, 0, 23, 5, 10'h006, 56);
      word("w7_fieldP",  10'h00C, 1'b1, 20, 23, 5, 10'h002, 56);
      word("w8_pdec",    10'h01C, 1'b1, 1, 0, 0,  10'h00C, 56);
      word("w9_pinc",    10'h03C, 1'b1, 1, 0, 13, 10'h01C, 56);
      word("w10_setP15", 10'h3CC, 1'b1, 1, 0, 0,  10'h03C, 56);
      word("w11_Mrun0",  10'h016, 1'b0, 1, 0, 13, 10'h3CC, 56);
      word("w12_Mrun1",  10'h016, 1'b1, 1, 0, 13, 10'h016, 56);
      word("w13_fieldM", 10'h01A, 1'b1, 12, 51, 13, 10'h016, 56);
      word("w14_partW",  10'h000, 1'b1, 0, 55, 13, 10'h01A, 30);

      rstb = 1'b0;
      #1;
      check("midrst.bit_cnt", 30, 16'(bit_cnt), 16'd0);
      check("midrst.ws", 30, 16'(ws), 16'd0);
      check("midrst.p_reg", 30, 16'(p_reg), 16'd0);
      check("midrst.instr", 30, 16'(instr), 16'd0);
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);

      word("w15_postrst", 10'h01A, 1'b1, 1, 0, 0,  10'h000, 56);
      word("w16_fieldW",  10'h000, 1'b1, 0, 55, 0, 10'h01A, 56);
      word("w17_cleared", 10'h000, 1'b1, 1, 0, 0,  10'h000, 56);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
